// File: rtl/sm_frame_max_if.sv
// Stream, result and status signals between sm_frame_max and its neighbours.
// The master side drives the frame and the ack; the slave side is the block itself.
interface sm_frame_max_if #(
    parameter int N = 8,
    parameter int L = 4
);
    logic         in_start;
    logic [L-1:0] in_len;
    logic [N-1:0] in_data;
    logic         in_valid;
    logic         o_ready;
    logic [N-1:0] o_max;
    logic [L-1:0] o_idx;
    logic         o_done;
    logic         in_ack;
    logic         o_busy;

    modport master (
        output in_start, in_len, in_data, in_valid, in_ack,
        input  o_ready, o_max, o_idx, o_done, o_busy
    );

    modport slave (
        input  in_start, in_len, in_data, in_valid, in_ack,
        output o_ready, o_max, o_idx, o_done, o_busy
    );
endinterface

// File: rtl/sm_frame_max.sv
// Running maximum and index of a frame of sign-magnitude samples,
// handed to the next stage with a done/ack handshake.
module sm_frame_max #(
    parameter int N = 8,
    parameter int L = 4
) (
    input  logic           in_clk,
    input  logic           in_rst_n,
    sm_frame_max_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

    localparam logic [L-1:0] ONE = L'(1);

    state_t       state, state_next;
    logic [L-1:0] count, len_q, last_idx;
    logic [N-1:0] max_q;
    logic [L-1:0] idx_q;
    logic         accept, start_ok;

    // +0 and -0 compare equal; negatives order by inverted magnitude.
    function automatic logic ge(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [N-2:0] ma;
        logic [N-2:0] mb;
        ma = a[N-2:0];
        mb = b[N-2:0];
        if (ma == '0 && mb == '0)
            return 1'b1;
        else if (a[N-1] != b[N-1])
            return ~a[N-1];
        else if (!a[N-1])
            return ma >= mb;
        else
            return ma <= mb;
    endfunction

    assign accept   = bus.in_valid && (state == COLLECT);
    assign start_ok = (state == IDLE) && bus.in_start && (bus.in_len != '0);
    assign last_idx = len_q - ONE;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_ok) state_next = COLLECT;
            COLLECT: if (accept && count == last_idx) state_next = DONE;
            DONE:    if (bus.in_ack) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge in_clk) begin
        if (!in_rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge in_clk) begin
        if (!in_rst_n) begin
            count <= '0;
            len_q <= '0;
            max_q <= '0;
            idx_q <= '0;
        end else begin
            if (start_ok) begin
                len_q <= bus.in_len;
                count <= '0;
            end
            if (accept) begin
                count <= count + ONE;
                // Strictly greater replaces, so ties keep the earlier index.
                if (count == '0 || !ge(max_q, bus.in_data)) begin
                    max_q <= bus.in_data;
                    idx_q <= count;
                end
            end
        end
    end

    assign bus.o_ready = (state == COLLECT);
    assign bus.o_done  = (state == DONE);
    assign bus.o_busy  = (state != IDLE);
    assign bus.o_max   = max_q;
    assign bus.o_idx   = idx_q;

endmodule

// File: doc/sm_frame_max.md
Name: sm_frame_max

Overview:
- Sequential stage directly downstream of the sign-magnitude A>=B compare function.
- Consumes a frame of sign-magnitude samples over a valid/ready stream.
- Tracks the running maximum and its index within the frame.
- Presents the result with a done/ack handshake to the next stage.

Parameters:
N, 8, sample width; bit N-1 = sign (1 = negative), bits N-2:0 = magnitude
L, 4, width of frame length and index; max frame length 2^L-1

Ports:
in_clk  input  1  clock, all state updates on rising edge
in_rst_n  input  1  synchronous active-low reset
in_start  input  1  start new frame; sampled only in IDLE
in_len  input  L  frame length in samples; latched on accepted start
in_data  input  N  sign-magnitude sample
in_valid  input  1  in_data valid
o_ready  output  1  block accepts a sample this cycle
o_max  output  N  maximum sample of the last/current frame, bit-exact as received
o_idx  output  L  0-based index of o_max within the frame
o_done  output  1  result valid; held until acknowledged
in_ack  input  1  consumer acknowledges result
o_busy  output  1  high in COLLECT or DONE

Behaviour:
- Reset (in_rst_n=0 at an edge): state IDLE; o_max=0, o_idx=0, o_done=0, o_ready=0, o_busy=0; internal count=0, latched length=0.
- Reset mid-frame or in DONE aborts immediately; partial result is discarded.
- Comparison rule, GE(a,b):
  - Both magnitudes zero -> 1, so +0 == -0.
  - Signs differ -> 1 iff a is positive.
  - Both positive -> mag(a) >= mag(b).
  - Both negative -> mag(a) <= mag(b).
- States and transitions:
  - IDLE -> COLLECT on in_start=1 with in_len!=0; latch in_len, clear count.
  - in_start with in_len=0 is ignored; state stays IDLE.
  - COLLECT -> DONE on the edge that accepts the sample where count == latched length-1.
  - DONE -> IDLE on in_ack=1.
- in_start is ignored outside IDLE. in_ack is ignored outside DONE.
- Output decoding: o_ready = (state==COLLECT); o_done = (state==DONE); o_busy = (state!=IDLE). All three are decoded from registered state.
- Accept: in_valid && o_ready at a rising edge. in_data is ignored when not accepted; bubbles (in_valid=0) are allowed.
- On accept:
  - count==0: o_max<=in_data, o_idx<=0 unconditionally.
  - Otherwise replace (o_max<=in_data, o_idx<=count) only if in_data is strictly greater, i.e. GE(o_max,in_data)==0.
  - Ties keep the earlier index.
  - count increments after every accept.
- Latency: o_done rises the cycle after the last sample is accepted. o_ready is low that same cycle, so no extra sample is taken.
- o_max/o_idx are stable throughout DONE. After ack they retain their value in IDLE until the first sample of the next frame.
- in_ack together with in_start in the same DONE cycle: ack is honoured, start is ignored; a new start is needed in IDLE.
- Length 2^L-1 is a full frame: count reaches 2^L-2 at the last accept and never wraps.
- Changes to in_len after latching have no effect on the current frame.

Test Plan:
- N=8, L=4. Reset, then start len=4, samples 0x05,0x83,0x07,0x02 with valid every cycle -> o_done high the cycle after 4th accept; o_max=0x07, o_idx=2; o_ready low in DONE.
- All negative, len=3: 0x85,0x81,0x83 -> o_max=0x81 (-1), o_idx=1.
- Tie and zero handling, len=3: 0x80,0x00,0x80 -> o_max=0x80, o_idx=0 (+0 == -0, earlier kept). Second frame len=2: 0x04,0x04 -> o_idx=0.
- Bubbles and hold:
  - Input: len=2 with valid pattern 1,0,0,1 and data 0x81,0x99,0x7F,0x03; in_ack withheld 5 cycles.
  - Expected: o_max=0x03, o_idx=1 held stable with o_done=1 for all 5 cycles.
  - Expected: in_start during DONE ignored; ack returns to IDLE.
- Boundaries:
  - in_start with in_len=0 -> stays IDLE, o_busy=0.
  - len=15 with the maximum 0x7F at index 14 -> o_idx=14, o_done after the 15th accept.
- Reset mid-COLLECT after 2 of 4 samples -> next cycle IDLE, o_max=0, o_idx=0, o_done=0; a fresh frame then completes correctly.
